// File: rtl/cnn1d_pkg.sv
// Shared types and helpers for the cnn1d pipeline classification head.
package cnn1d_pkg;

  // Argmax controller state, exposed on a debug port for checkers.
  typedef logic [1:0] argmax_state_t;

  localparam argmax_state_t ARGMAX_IDLE = 2'd0;
  localparam argmax_state_t ARGMAX_SCAN = 2'd1;
  localparam argmax_state_t ARGMAX_DONE = 2'd2;

  // Index width for n classes, never narrower than one bit.
  function automatic int argmax_class_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/argmax_update.sv
// One step of the running argmax: folds score x at position idx into the
// (best, second, best_idx) triple. Strict signed compares mean an equal
// later score never displaces an earlier winner, so the lowest index wins
// ties and the tied value lands in second, giving a zero margin.
module argmax_update #(
  parameter int DATA_WIDTH  = 32,
  parameter int CLASS_WIDTH = 1
) (
  input  logic [DATA_WIDTH-1:0]  x_i,
  input  logic [CLASS_WIDTH-1:0] idx_i,
  input  logic [DATA_WIDTH-1:0]  best_i,
  input  logic [DATA_WIDTH-1:0]  second_i,
  input  logic [CLASS_WIDTH-1:0] best_idx_i,
  output logic [DATA_WIDTH-1:0]  best_o,
  output logic [DATA_WIDTH-1:0]  second_o,
  output logic [CLASS_WIDTH-1:0] best_idx_o
);

  // Signed compare-and-shift of the top two scores.
  always_comb begin
    best_o     = best_i;
    second_o   = second_i;
    best_idx_o = best_idx_i;
    if ($signed(x_i) > $signed(best_i)) begin
      second_o   = best_i;
      best_o     = x_i;
      best_idx_o = idx_i;
    end else if ($signed(x_i) > $signed(second_i)) begin
      second_o = x_i;
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// Serial N-class argmax head: captures a score vector, scans one score per
// cycle, then presents class, score, winner-to-runner-up margin and a
// low-confidence flag until downstream takes them.
//
// Handshakes: a transfer happens on a rising clk edge where both valid and
// ready are high. Input side: ready_in is high only in IDLE (after reset
// has been released) and a vector transfers when every per-class valid is
// high together with ready_in. Output side: valid_out is high in DONE and
// stays high, with all result outputs frozen, until ready_out is seen.
module argmax_classifier
  import cnn1d_pkg::*;
#(
  parameter int          DATA_WIDTH       = 32,
  parameter int          NUM_CLASSES      = 2,
  parameter int unsigned MARGIN_THRESHOLD = 0,
  localparam int         CLASS_WIDTH      = argmax_class_width(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   argmax_ready_in,
  input  logic [0:NUM_CLASSES-1] argmax_valid_in,
  input  logic [DATA_WIDTH-1:0]  argmax_data_in [0:NUM_CLASSES-1],
  input  logic                   argmax_ready_out,
  output logic                   argmax_valid_out,
  output logic [CLASS_WIDTH-1:0] argmax_class_out,
  output logic [DATA_WIDTH-1:0]  argmax_score_out,
  output logic [DATA_WIDTH-1:0]  argmax_margin_out,
  output logic                   argmax_low_conf_out,
  output argmax_state_t          argmax_state_dbg
);

  localparam logic [DATA_WIDTH-1:0]  MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CLASS_WIDTH-1:0] LAST_IDX = CLASS_WIDTH'(NUM_CLASSES - 1);
  localparam logic [DATA_WIDTH:0]    THRESH   = (DATA_WIDTH+1)'(MARGIN_THRESHOLD);

  argmax_state_t          state_q, state_d;
  logic                   init_q, init_d;
  logic [CLASS_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  vec_q [0:NUM_CLASSES-1];
  logic [DATA_WIDTH-1:0]  vec_d [0:NUM_CLASSES-1];
  logic [DATA_WIDTH-1:0]  best_q, best_d, second_q, second_d;
  logic [CLASS_WIDTH-1:0] best_idx_q, best_idx_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic [DATA_WIDTH-1:0]  score_q, score_d, margin_q, margin_d;
  logic                   low_conf_q, low_conf_d;

  logic                   accept;
  logic [DATA_WIDTH-1:0]  scan_x;
  logic [DATA_WIDTH-1:0]  upd_best, upd_second;
  logic [CLASS_WIDTH-1:0] upd_idx;
  logic [DATA_WIDTH:0]    diff;
  logic [DATA_WIDTH-1:0]  margin_next;
  logic                   low_conf_next;

  assign argmax_ready_in     = (state_q == ARGMAX_IDLE) && init_q;
  assign accept              = argmax_ready_in && (&argmax_valid_in);
  assign argmax_valid_out    = (state_q == ARGMAX_DONE);
  assign argmax_class_out    = class_q;
  assign argmax_score_out    = score_q;
  assign argmax_margin_out   = margin_q;
  assign argmax_low_conf_out = low_conf_q;
  assign argmax_state_dbg    = state_q;

  // Select the captured score addressed by the scan counter.
  always_comb begin
    scan_x = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cnt_q == CLASS_WIDTH'(i)) scan_x = vec_q[i];
    end
  end

  argmax_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .CLASS_WIDTH(CLASS_WIDTH)
  ) u_update (
    .x_i       (scan_x),
    .idx_i     (cnt_q),
    .best_i    (best_q),
    .second_i  (second_q),
    .best_idx_i(best_idx_q),
    .best_o    (upd_best),
    .second_o  (upd_second),
    .best_idx_o(upd_idx)
  );

  // Margin in one extra bit so best - second never overflows; a single
  // class has no runner-up and reports full confidence.
  always_comb begin
    diff          = {upd_best[DATA_WIDTH-1], upd_best} - {upd_second[DATA_WIDTH-1], upd_second};
    margin_next   = diff[DATA_WIDTH-1:0];
    low_conf_next = (diff < THRESH);
    if (NUM_CLASSES == 1) begin
      margin_next   = '1;
      low_conf_next = ({1'b0, {DATA_WIDTH{1'b1}}} < THRESH);
    end
  end

  // Controller: capture on accept, scan one score per cycle, hold in DONE.
  always_comb begin
    state_d    = state_q;
    init_d     = 1'b1;
    cnt_d      = cnt_q;
    vec_d      = vec_q;
    best_d     = best_q;
    second_d   = second_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    score_d    = score_q;
    margin_d   = margin_q;
    low_conf_d = low_conf_q;
    case (state_q)
      ARGMAX_IDLE: begin
        if (accept) begin
          state_d    = ARGMAX_SCAN;
          cnt_d      = '0;
          vec_d      = argmax_data_in;
          best_d     = MOST_NEG;
          second_d   = MOST_NEG;
          best_idx_d = '0;
        end
      end
      ARGMAX_SCAN: begin
        best_d     = upd_best;
        second_d   = upd_second;
        best_idx_d = upd_idx;
        if (cnt_q == LAST_IDX) begin
          state_d    = ARGMAX_DONE;
          class_d    = upd_idx;
          score_d    = upd_best;
          margin_d   = margin_next;
          low_conf_d = low_conf_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARGMAX_DONE: begin
        if (argmax_ready_out) state_d = ARGMAX_IDLE;
      end
      default: state_d = ARGMAX_IDLE;
    endcase
  end

  // State and datapath registers, cleared by asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARGMAX_IDLE;
      init_q     <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) vec_q[i] <= '0;
      best_q     <= '0;
      second_q   <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      score_q    <= '0;
      margin_q   <= '0;
      low_conf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_q     <= init_d;
      cnt_q      <= cnt_d;
      vec_q      <= vec_d;
      best_q     <= best_d;
      second_q   <= second_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
      score_q    <= score_d;
      margin_q   <= margin_d;
      low_conf_q <= low_conf_d;
    end
  end

endmodule

// File: tb/tb_argmax_classifier.sv
// Bench for argmax_classifier: three instances (2, 4 and 3 classes) share
// one clock and reset. Directed vectors push hand-computed results into
// per-instance queues; a forked monitor pops and compares on each output
// handshake. Timing checks (latency, stall, reset) run inline.
module tb_argmax_classifier;
  import cnn1d_pkg::*;

  logic clk;
  logic rst;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u2: 2 classes, threshold 0
  logic [0:1]  v2;
  logic [15:0] d2 [0:1];
  logic        ro2, rdy2, vo2, cls2, lc2;
  logic [15:0] sc2, mg2;
  argmax_state_t st2;

  // u4: 4 classes, threshold 0
  logic [0:3]  v4;
  logic [15:0] d4 [0:3];
  logic        ro4, rdy4, vo4, lc4;
  logic [1:0]  cls4;
  logic [15:0] sc4, mg4;
  argmax_state_t st4;

  // u3: 3 classes, threshold 3
  logic [0:2]  v3;
  logic [15:0] d3 [0:2];
  logic        ro3, rdy3, vo3, lc3;
  logic [1:0]  cls3;
  logic [15:0] sc3, mg3;
  argmax_state_t st3;

  argmax_classifier #(.DATA_WIDTH(16), .NUM_CLASSES(2), .MARGIN_THRESHOLD(0)) u2 (
    .clk(clk), .rst(rst), .argmax_ready_in(rdy2), .argmax_valid_in(v2),
    .argmax_data_in(d2), .argmax_ready_out(ro2), .argmax_valid_out(vo2),
    .argmax_class_out(cls2), .argmax_score_out(sc2), .argmax_margin_out(mg2),
    .argmax_low_conf_out(lc2), .argmax_state_dbg(st2)
  );

  argmax_classifier #(.DATA_WIDTH(16), .NUM_CLASSES(4), .MARGIN_THRESHOLD(0)) u4 (
    .clk(clk), .rst(rst), .argmax_ready_in(rdy4), .argmax_valid_in(v4),
    .argmax_data_in(d4), .argmax_ready_out(ro4), .argmax_valid_out(vo4),
    .argmax_class_out(cls4), .argmax_score_out(sc4), .argmax_margin_out(mg4),
    .argmax_low_conf_out(lc4), .argmax_state_dbg(st4)
  );

  argmax_classifier #(.DATA_WIDTH(16), .NUM_CLASSES(3), .MARGIN_THRESHOLD(3)) u3 (
    .clk(clk), .rst(rst), .argmax_ready_in(rdy3), .argmax_valid_in(v3),
    .argmax_data_in(d3), .argmax_ready_out(ro3), .argmax_valid_out(vo3),
    .argmax_class_out(cls3), .argmax_score_out(sc3), .argmax_margin_out(mg3),
    .argmax_low_conf_out(lc3), .argmax_state_dbg(st3)
  );

  // result word: {class[1:0], score[15:0], margin[15:0], low_conf}
  logic [34:0] act2, act3, act4;
  assign act2 = {1'b0, cls2, sc2, mg2, lc2};
  assign act3 = {cls3, sc3, mg3, lc3};
  assign act4 = {cls4, sc4, mg4, lc4};

  // scoreboard
  logic [34:0] exp_q2[$];
  logic [34:0] exp_q3[$];
  logic [34:0] exp_q4[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [34:0] mk(input logic [1:0] c, input logic [15:0] s,
                                     input logic [15:0] m, input logic lc);
    return {c, s, m, lc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic rdy_of(input int inst);
    case (inst)
      2:       return rdy2;
      3:       return rdy3;
      default: return rdy4;
    endcase
  endfunction

  function automatic logic vo_of(input int inst);
    case (inst)
      2:       return vo2;
      3:       return vo3;
      default: return vo4;
    endcase
  endfunction

  // monitor: pop and compare on every output handshake
  task automatic monitor();
    logic [34:0] e;
    forever begin
      @(negedge clk);
      if (vo2 && ro2) begin
        if (exp_q2.size() == 0) begin
          total++; bad++;
          $display("FAIL u2_unexpected got=%h exp=none", act2);
        end else begin
          e = exp_q2.pop_front();
          check("u2_result", {29'd0, act2}, {29'd0, e});
        end
      end
      if (vo3 && ro3) begin
        if (exp_q3.size() == 0) begin
          total++; bad++;
          $display("FAIL u3_unexpected got=%h exp=none", act3);
        end else begin
          e = exp_q3.pop_front();
          check("u3_result", {29'd0, act3}, {29'd0, e});
        end
      end
      if (vo4 && ro4) begin
        if (exp_q4.size() == 0) begin
          total++; bad++;
          $display("FAIL u4_unexpected got=%h exp=none", act4);
        end else begin
          e = exp_q4.pop_front();
          check("u4_result", {29'd0, act4}, {29'd0, e});
        end
      end
    end
  endtask

  // driver: present a full vector, wait for ready, push expected, accept.
  // Returns 1 time unit after the accept edge with valids dropped.
  task automatic send(input int inst, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] e, input logic [34:0] exp);
    int n;
    n = 0;
    case (inst)
      2: begin d2[0] = a; d2[1] = b; v2 = '1; end
      3: begin d3[0] = a; d3[1] = b; d3[2] = c; v3 = '1; end
      default: begin d4[0] = a; d4[1] = b; d4[2] = c; d4[3] = e; v4 = '1; end
    endcase
    while (!rdy_of(inst) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL send_timeout inst=%0d got=busy exp=ready", inst);
    end else begin
      case (inst)
        2:       exp_q2.push_back(exp);
        3:       exp_q3.push_back(exp);
        default: exp_q4.push_back(exp);
      endcase
      @(posedge clk); #1;
    end
    v2 = '0; v3 = '0; v4 = '0;
  endtask

  // valid_out must be low for nc-1 edges after accept and high after edge nc
  task automatic check_latency(input int inst, input int nc, input string name);
    for (int i = 1; i <= nc; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s_edge%0d", name, i), {63'd0, vo_of(inst)}, {63'd0, (i == nc)});
    end
  endtask

  initial begin
    int n;
    rst = 1'b0;
    ro2 = 1'b1; ro3 = 1'b1; ro4 = 1'b1;
    v2 = '0; v3 = '0; v4 = '0;
    for (int i = 0; i < 2; i++) d2[i] = '0;
    for (int i = 0; i < 3; i++) d3[i] = '0;
    for (int i = 0; i < 4; i++) d4[i] = '0;
    fork
      monitor();
    join_none

    // reset: everything low, including ready_in
    #12;
    check("reset_outs_u2", {rdy2, vo2, act2, st2}, 64'd0);
    check("reset_outs_u3", {rdy3, vo3, act3, st3}, 64'd0);
    check("reset_outs_u4", {rdy4, vo4, act4, st4}, 64'd0);
    #10;
    rst = 1'b1;
    #1;
    check("ready_before_first_edge", {61'd0, rdy2, rdy3, rdy4}, 64'd0);
    @(posedge clk); #1;
    check("ready_after_first_edge", {61'd0, rdy2, rdy3, rdy4}, 64'd7);

    // two-class decisions
    send(2, 16'h0100, 16'h0200, 16'h0, 16'h0, mk(2'd1, 16'h0200, 16'h0100, 1'b0));
    check_latency(2, 2, "u2_latency");
    send(2, 16'h0200, 16'h0100, 16'h0, 16'h0, mk(2'd0, 16'h0200, 16'h0100, 1'b0));
    send(2, 16'h0050, 16'h0050, 16'h0, 16'h0, mk(2'd0, 16'h0050, 16'h0000, 1'b0));
    send(2, 16'hFFFF, 16'h0000, 16'h0, 16'h0, mk(2'd1, 16'h0000, 16'h0001, 1'b0));

    // signed scores, extremes and ties
    send(4, 16'hFFFB, 16'hFFFE, 16'hFFF7, 16'hFFFD, mk(2'd1, 16'hFFFE, 16'h0001, 1'b0));
    send(4, 16'h8000, 16'h7FFF, 16'h0000, 16'h0000, mk(2'd1, 16'h7FFF, 16'h7FFF, 1'b0));
    send(4, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, mk(2'd1, 16'h7FFF, 16'hFFFF, 1'b0));
    send(4, 16'h0003, 16'h0009, 16'h0009, 16'h0002, mk(2'd1, 16'h0009, 16'h0000, 1'b0));

    // confidence against threshold 3
    send(3, 16'd10, 16'd8, 16'd1, 16'd0, mk(2'd0, 16'd10, 16'd2, 1'b1));
    send(3, 16'd10, 16'd5, 16'd1, 16'd0, mk(2'd0, 16'd10, 16'd5, 1'b0));
    send(3, 16'd1,  16'd4, 16'd1, 16'd0, mk(2'd1, 16'd4,  16'd3, 1'b0));

    // latency and long output stall
    ro4 = 1'b0;
    send(4, 16'd10, 16'd20, 16'd30, 16'd40, mk(2'd3, 16'd40, 16'd10, 1'b0));
    check_latency(4, 4, "u4_latency");
    repeat (10) begin
      @(posedge clk); #1;
      check("u4_stall_hold", {rdy4, vo4, act4}, {27'd0, 1'b0, 1'b1, mk(2'd3, 16'd40, 16'd10, 1'b0)});
    end
    ro4 = 1'b1;
    @(posedge clk); #1;
    check("u4_ready_after_release", {62'd0, rdy4, vo4}, 64'd2);

    // partial valids: no capture until the vector is complete
    d4[0] = 16'd7; d4[1] = 16'd1; d4[2] = 16'd2; d4[3] = 16'd3;
    v4 = 4'b1101;
    repeat (6) begin
      @(posedge clk); #1;
      check("u4_partial_wait", {61'd0, rdy4, st4}, {61'd0, 1'b1, ARGMAX_IDLE});
    end
    send(4, 16'd7, 16'd1, 16'd2, 16'd3, mk(2'd0, 16'd7, 16'd4, 1'b0));

    // inputs disturbed during scan must not leak into the result
    send(4, 16'd1, 16'd5, 16'd4, 16'd2, mk(2'd1, 16'd5, 16'd1, 1'b0));
    d4[0] = 16'h7FFF; d4[1] = 16'h7FFF; d4[2] = 16'h7FFF; d4[3] = 16'h7FFF;
    v4 = '1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    v4 = '0;

    // asynchronous reset mid-scan, off the clock edge
    send(4, 16'd5, 16'd6, 16'd7, 16'd8, mk(2'd3, 16'd8, 16'd1, 1'b0));
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("async_rst_u4", {rdy4, vo4, act4, st4}, 64'd0);
    check("async_rst_u2", {rdy2, vo2, act2, st2}, 64'd0);
    check("async_rst_u3", {rdy3, vo3, act3, st3}, 64'd0);
    exp_q4.delete();
    @(negedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_midop_reset", {63'd0, rdy2}, 64'd1);
    send(2, 16'd1, 16'd7, 16'd0, 16'd0, mk(2'd1, 16'd7, 16'd6, 1'b0));
    check_latency(2, 2, "u2_latency_after_reset");

    // drain outstanding results
    n = 0;
    while ((exp_q2.size() + exp_q3.size() + exp_q4.size()) != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("queues_drained", 64'(exp_q2.size() + exp_q3.size() + exp_q4.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
